legv8_multicycle_control: RTL and testbench

Multi-cycle control unit for the LEGv8 datapath. It sequences fetch, decode, execute, memory and write-back for R-type, LDUR, STUR, CBZ and B instructions. It drives the immediate-format select consumed by the sign extender, plus all register-file, ALU, PC and memory enables. It sits beside the instruction register and handshakes with a single shared instruction/data memory port.

---
 rtl/legv8_multicycle_control.sv | 230 +++++++++++++++++++++++
 tb/tb_legv8_multicycle_control.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_control.sv
// -----------------------------------------------------------------------------
// legv8_multicycle_control
//
// Multi-cycle control unit for the LEGv8 datapath. It sequences fetch, decode,
// execute, memory and write-back for R-type, LDUR, STUR, CBZ and B, and
// handshakes with a single shared instruction/data memory port.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   run               level; leaves IDLE when high (only sampled in IDLE)
//   instruction[31:0] instruction register contents (valid from DECODE on)
//   zero              ALU zero flag; the datapath combines it with
//                     pc_write_cond
//   mem_ready         memory completes the current access this cycle
//   ir_write, pc_write, pc_write_cond   register enables
//   iord              memory address source (0 = PC, 1 = ALUOut)
//   mem_read, mem_write                 memory strobes
//   reg_write, reg2loc, mem_to_reg      register-file controls
//   alu_src_a         0 = PC, 1 = register A
//   alu_src_b[1:0]    00 = B, 01 = 4, 10 = imm, 11 = imm << 2
//   alu_op[1:0]       00 add, 01 pass-B/zero test, 10 funct-decoded
//   imm_sel[1:0]      00 = B format, 10 = CBZ format, 11 = D format
//   pc_source[1:0]    00 = ALU, 01 = ALUOut
//   halted            illegal opcode seen; sticky until rst
//   retired[15:0]     retired-instruction counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module legv8_multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg2loc,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic [1:0]  pc_source,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_ADDR,
        S_MEM_LD,
        S_MEM_ST,
        S_WB_R,
        S_WB_LD,
        S_BR_CBZ,
        S_BR_B,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;

    // ------------------------------------------------------------------
    // Opcode classification (the classes are mutually exclusive)
    // ------------------------------------------------------------------
    logic is_b, is_cbz, is_ldur, is_stur, is_r;

    always_comb begin
        is_b    = (instruction[31:26] == 6'b000101);
        is_cbz  = (instruction[31:24] == 8'b10110100);
        is_ldur = (instruction[31:21] == 11'b11111000010);
        is_stur = (instruction[31:21] == 11'b11111000000);
        is_r    = (instruction[31:21] == 11'b10001011000) ||
                  (instruction[31:21] == 11'b11001011000) ||
                  (instruction[31:21] == 11'b10001010000) ||
                  (instruction[31:21] == 11'b10101010000);
    end

    // The zero flag is gated with pc_write_cond in the datapath, and the low
    // instruction bits are operand fields; neither steers this FSM.
    logic unused_inputs;
    assign unused_inputs = ^{zero, instruction[20:0]};

    // ------------------------------------------------------------------
    // State and retire-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

    // Final cycle of every instruction; a store retires only once memory
    // accepts it.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WB_R, S_WB_LD, S_BR_CBZ, S_BR_B: retire = 1'b1;
            S_MEM_ST:                          retire = mem_ready;
            default:                           retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + 16'd1 : retired_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run) state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_r)                    state_d = S_EX_R;
                else if (is_ldur || is_stur) state_d = S_EX_ADDR;
                else if (is_cbz)             state_d = S_BR_CBZ;
                else if (is_b)               state_d = S_BR_B;
                else                         state_d = S_HALT;
            end
            S_EX_R:    state_d = S_WB_R;
            S_EX_ADDR: state_d = is_ldur ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:  if (mem_ready) state_d = S_WB_LD;
            S_MEM_ST:  if (mem_ready) state_d = S_FETCH;
            S_WB_R:    state_d = S_FETCH;
            S_WB_LD:   state_d = S_FETCH;
            S_BR_CBZ:  state_d = S_FETCH;
            S_BR_B:    state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except the mem_ready-qualified fetch enables
    // and the opcode-qualified decode controls)
    // ------------------------------------------------------------------
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg2loc       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        imm_sel       = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC + 4 computed by the ALU while memory returns the word.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2) into ALUOut.
                alu_src_b = 2'b11;
                reg2loc   = is_cbz || is_stur;
                if (is_b)        imm_sel = 2'b00;
                else if (is_cbz) imm_sel = 2'b10;
                else             imm_sel = 2'b11;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_EX_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                imm_sel   = 2'b11;
            end
            S_MEM_LD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_ST: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
            end
            S_WB_R: begin
                reg_write = 1'b1;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BR_CBZ: begin
                reg2loc       = 1'b1;
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_BR_B: begin
                pc_write  = 1'b1;
                pc_source = 2'b01;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// -----------------------------------------------------------------------------
// Testbench for legv8_multicycle_control. A trace generator expands each
// instruction (with chosen memory wait counts) into the expected per-cycle
// sequence of control outputs; the bench replays that trace against the DUT.
// -----------------------------------------------------------------------------
module tb_legv8_multicycle_control;

    logic        clk = 1'b0;
    logic        rst, run, zero, mem_ready;
    logic [31:0] instruction;
    logic        ir_write, pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic        reg_write, reg2loc, mem_to_reg, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, imm_sel, pc_source;
    logic [15:0] retired;

    always #5 clk = ~clk;

    legv8_multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .instruction   (instruction),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg2loc       (reg2loc),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_sel       (imm_sel),
        .pc_source     (pc_source),
        .halted        (halted),
        .retired       (retired)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg2loc;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_sel;
        logic [1:0] pc_source;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        run;
        logic        mr;
        logic        z;
        outs_t       exp;
        bit          retire;
        string       tag;
    } cyc_t;

    outs_t act;
    assign act = {ir_write, pc_write, pc_write_cond, iord, mem_read, mem_write,
                  reg_write, reg2loc, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  imm_sel, pc_source, halted};

    localparam int C_B = 0, C_CBZ = 1, C_LDUR = 2, C_STUR = 3, C_R = 4, C_ILL = 5;

    int          errors = 0;
    int          checks = 0;
    int          cyc_no = 0;
    logic [15:0] model_ret;
    cyc_t        trace[$];

    function automatic int classify(input logic [31:0] w);
        logic [10:0] op11;
        op11 = w[31:21];
        if (w[31:26] == 6'b000101)   return C_B;
        if (w[31:24] == 8'hB4)       return C_CBZ;
        if (op11 == 11'h7C2)         return C_LDUR;
        if (op11 == 11'h7C0)         return C_STUR;
        if (op11 == 11'h458 || op11 == 11'h658 ||
            op11 == 11'h450 || op11 == 11'h550) return C_R;
        return C_ILL;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] rand_legal(input int cls);
        logic [31:0] r;
        logic [10:0] rops[4];
        rops[0] = 11'h458; rops[1] = 11'h658; rops[2] = 11'h450; rops[3] = 11'h550;
        r = $urandom;
        case (cls)
            C_B:    return {6'b000101, r[25:0]};
            C_CBZ:  return {8'hB4, r[23:0]};
            C_LDUR: return {11'h7C2, r[20:0]};
            C_STUR: return {11'h7C0, r[20:0]};
            default: return {rops[$urandom_range(0, 3)], r[20:0]};
        endcase
    endfunction

    task automatic push(input logic [31:0] ins, input logic r, input logic mr,
                        input logic z, input outs_t e, input bit ret, input string tag);
        cyc_t c;
        c.instr = ins; c.run = r; c.mr = mr; c.z = z;
        c.exp = e; c.retire = ret; c.tag = tag;
        trace.push_back(c);
    endtask

    task automatic gen_idle(input logic r, input int n);
        for (int i = 0; i < n; i++) push($urandom, r, rbit(), rbit(), '0, 1'b0, "idle");
    endtask

    task automatic gen_halt(input int n);
        outs_t e;
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < n; i++) push($urandom, rbit(), rbit(), rbit(), e, 1'b0, "halt");
    endtask

    // Expected cycle sequence of one instruction: fw fetch waits, mw data waits.
    task automatic gen_instr(input logic [31:0] w, input int fw, input int mw, input logic z);
        int    cls;
        outs_t e;
        cls = classify(w);
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            if (i == fw) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            push($urandom, rbit(), (i == fw), rbit(), e, 1'b0, "fetch");
        end
        e = '0; e.alu_src_b = 2'b11;
        e.imm_sel = (cls == C_B) ? 2'b00 : (cls == C_CBZ) ? 2'b10 : 2'b11;
        e.reg2loc = (cls == C_CBZ) || (cls == C_STUR);
        push(w, rbit(), rbit(), rbit(), e, 1'b0, "decode");
        case (cls)
            C_R: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                push(w, rbit(), rbit(), rbit(), e, 1'b0, "ex_r");
                e = '0; e.reg_write = 1'b1;
                push(w, rbit(), rbit(), rbit(), e, 1'b1, "wb_r");
            end
            C_LDUR, C_STUR: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.imm_sel = 2'b11;
                push(w, rbit(), rbit(), rbit(), e, 1'b0, "ex_addr");
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (cls == C_LDUR) e.mem_read = 1'b1;
                    else begin e.mem_write = 1'b1; e.reg2loc = 1'b1; end
                    push(w, rbit(), (i == mw), rbit(), e,
                         (cls == C_STUR) && (i == mw), (cls == C_LDUR) ? "mem_ld" : "mem_st");
                end
                if (cls == C_LDUR) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    push(w, rbit(), rbit(), rbit(), e, 1'b1, "wb_ld");
                end
            end
            C_CBZ: begin
                e = '0; e.reg2loc = 1'b1; e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                e.pc_write_cond = 1'b1; e.pc_source = 2'b01;
                push(w, rbit(), rbit(), z, e, 1'b1, "br_cbz");
            end
            C_B: begin
                e = '0; e.pc_write = 1'b1; e.pc_source = 2'b01;
                push(w, rbit(), rbit(), rbit(), e, 1'b1, "br_b");
            end
            default: ;
        endcase
    endtask

    // Replays the trace; entered and left at posedge + 1.
    task automatic run_trace(input bit rst_last);
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            run = c.run; mem_ready = c.mr; zero = c.z; instruction = c.instr;
            @(negedge clk);
            cyc_no++;
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got=%05h expected=%05h",
                         c.tag, cyc_no, act, c.exp);
            end
            checks++;
            if (retired !== model_ret) begin
                errors++;
                $display("FAIL retired(%s) cycle %0d: got=%04h expected=%04h",
                         c.tag, cyc_no, retired, model_ret);
            end
            if (c.retire) model_ret = model_ret + 16'd1;
            if (rst_last && trace.size() == 0) rst = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; model_ret = '0;
        gen_idle(1'b0, 5);
        run_trace(1'b0);
    endtask

    task automatic test_rtype_add();
        gen_idle(1'b1, 1);
        gen_instr(32'h8B020020, 0, 0, 1'b0);
        run_trace(1'b0);
    endtask

    task automatic test_ldur_wait();
        gen_instr(32'hF8408020, 2, 2, 1'b0);
        run_trace(1'b0);
    endtask

    task automatic test_cbz();
        gen_instr(32'hB4000040, 0, 0, 1'b1);
        gen_instr(32'hB4000040, 0, 0, 1'b0);
        run_trace(1'b0);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++)
            gen_instr(rand_legal($urandom_range(0, 4)), $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit());
        run_trace(1'b0);
    endtask

    task automatic test_counter_wrap();
        // Currently in a FETCH cycle, which never retires.
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        model_ret = 16'hFFFF;
        gen_instr(rand_legal(C_B), 0, 0, 1'b0);
        gen_instr(rand_legal(C_B), 1, 0, 1'b0);
        run_trace(1'b0);
    endtask

    task automatic test_b_then_illegal();
        gen_instr(32'h14000010, 0, 0, 1'b0);
        gen_instr(32'h00000000, 0, 0, 1'b0);
        gen_halt(10);
        run_trace(1'b0);
    endtask

    task automatic test_reset_mid_wait();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; model_ret = '0;
        gen_idle(1'b1, 1);
        gen_instr(rand_legal(C_STUR), 1, 4, 1'b0);
        // Keep idle + 2 fetch + decode + ex_addr + first MEM_ST wait cycle.
        while (trace.size() > 6) void'(trace.pop_back());
        run_trace(1'b1);
        rst = 1'b0; model_ret = '0;
        gen_idle(1'b0, 2);
        run_trace(1'b0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; instruction = '0;
        model_ret = '0;
        test_reset();
        test_rtype_add();
        test_ldur_wait();
        test_cbz();
        test_back_to_back_random();
        test_counter_wrap();
        test_b_then_illegal();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
